jtgng_dwnld_router: RTL

- Parametrised successor to the per-game PROM/ROM load decoder.
- Sits between the ioctl download stream and both the SDRAM programming port and the on-chip PROM write strobes.
- Splits the download byte stream into up to four SDRAM banks plus N on-chip PROM slots.
- Buffers one write against SDRAM back-pressure and sequences the game reset after download completes.

---
 rtl/jtgng_dwnld_router.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/jtgng_dwnld_router.sv
// Routes the ioctl download stream into four SDRAM banks and a row of on-chip
// PROM slots, buffers SDRAM writes against back-pressure, sequences rst_game.
module jtgng_dwnld_router #(
    parameter int             AW         = 22,
    parameter logic [AW-1:0]  BA1_START  = 22'h08000,
    parameter logic [AW-1:0]  BA2_START  = 22'h28000,
    parameter logic [AW-1:0]  BA3_START  = 22'h48000,
    parameter logic [AW-1:0]  PROM_START = 22'h88000,
    parameter int             PROM_CNT   = 13,
    parameter int             PROM_AW    = 8,
    parameter bit             SWAB       = 1'b0,
    parameter int             HOLD       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic                ioctl_wr,
    input  logic [AW-1:0]       ioctl_addr,
    input  logic [7:0]          ioctl_data,
    output logic                prog_we,
    input  logic                prog_rdy,
    output logic [1:0]          prog_ba,
    output logic [AW-2:0]       prog_addr,
    output logic [15:0]         prog_data,
    output logic [1:0]          prog_mask,
    output logic [PROM_CNT-1:0] prom_we,
    output logic [PROM_AW-1:0]  prom_addr,
    output logic [7:0]          prom_data,
    output logic                overrun,
    output logic                oob,
    output logic                rst_game
);

    localparam int IW = AW - PROM_AW;
    localparam int CW = $clog2(HOLD + 1);

    typedef struct packed {
        logic [1:0]    ba;
        logic [AW-2:0] addr;
        logic [15:0]   data;
        logic [1:0]    mask;
    } ent_t;

    localparam ent_t RST_ENT = '{ba: 2'd0, addr: '0, data: 16'd0, mask: 2'b11};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_HOLD, S_RUN} state_t;

    // ---------------- input decode ----------------
    logic                w_wr, w_sd_wr, w_pr_wr, w_pr_hit, w_pr_oob;
    logic [AW-1:0]       w_poff, w_base;
    logic [IW-1:0]       w_idx;
    logic [1:0]          w_ba;
    logic [PROM_CNT-1:0] w_prom_oh;
    ent_t                w_new;
    logic                w_dl_rise, w_drop;

    assign w_wr     = ioctl_wr & downloading;
    assign w_sd_wr  = w_wr && (ioctl_addr < PROM_START);
    assign w_pr_wr  = w_wr && (ioctl_addr >= PROM_START);
    assign w_poff   = ioctl_addr - PROM_START;
    assign w_idx    = IW'(w_poff >> PROM_AW);
    assign w_pr_hit = w_pr_wr && (w_idx < IW'(PROM_CNT));
    assign w_pr_oob = w_pr_wr && !(w_idx < IW'(PROM_CNT));

    always_comb begin
        w_ba   = 2'd0;
        w_base = '0;
        if (ioctl_addr >= BA3_START) begin
            w_ba   = 2'd3;
            w_base = BA3_START;
        end else if (ioctl_addr >= BA2_START) begin
            w_ba   = 2'd2;
            w_base = BA2_START;
        end else if (ioctl_addr >= BA1_START) begin
            w_ba   = 2'd1;
            w_base = BA1_START;
        end
    end

    always_comb begin
        w_new.ba   = w_ba;
        w_new.addr = (AW-1)'((ioctl_addr - w_base) >> 1);
        w_new.data = {ioctl_data, ioctl_data};
        w_new.mask = (ioctl_addr[0] ? 2'b01 : 2'b10) ^ {2{SWAB}};
    end

    always_comb begin
        w_prom_oh = '0;
        for (int i = 0; i < PROM_CNT; i++)
            w_prom_oh[i] = w_pr_hit && (w_idx == IW'(i));
    end

    // ---------------- SDRAM output register + skid ----------------
    ent_t r_out, r_skid;
    logic r_we, r_skid_vld, r_ovr, r_oob, r_dl_d;

    // A write arriving alongside prog_rdy sees the released slot, so only a
    // still-busy output register with a full skid loses data.
    assign w_drop    = w_sd_wr && r_we && !prog_rdy && r_skid_vld;
    assign w_dl_rise = downloading && !r_dl_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out      <= RST_ENT;
            r_skid     <= RST_ENT;
            r_we       <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (!r_we || prog_rdy) begin
            if (r_skid_vld) begin
                r_out      <= r_skid;
                r_we       <= 1'b1;
                r_skid_vld <= w_sd_wr;
                if (w_sd_wr) r_skid <= w_new;
            end else if (w_sd_wr) begin
                r_out <= w_new;
                r_we  <= 1'b1;
            end else begin
                r_we <= 1'b0;
            end
        end else if (w_sd_wr && !r_skid_vld) begin
            r_skid     <= w_new;
            r_skid_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dl_d <= 1'b0;
            r_ovr  <= 1'b0;
            r_oob  <= 1'b0;
        end else begin
            r_dl_d <= downloading;
            r_ovr  <= w_dl_rise ? w_drop   : (r_ovr | w_drop);
            r_oob  <= w_dl_rise ? w_pr_oob : (r_oob | w_pr_oob);
        end
    end

    // ---------------- PROM strobes ----------------
    logic [PROM_CNT-1:0] r_prom_we;
    logic [PROM_AW-1:0]  r_prom_addr;
    logic [7:0]          r_prom_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prom_we   <= '0;
            r_prom_addr <= '0;
            r_prom_data <= 8'd0;
        end else begin
            r_prom_we <= w_prom_oh;
            if (w_pr_hit) begin
                r_prom_addr <= PROM_AW'(w_poff);
                r_prom_data <= ioctl_data;
            end
        end
    end

    // ---------------- game reset sequencer ----------------
    state_t         r_state, w_nstate;
    logic [CW-1:0]  r_cnt, w_ncnt;
    logic           r_rst_game;

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        case (r_state)
            S_IDLE:  if (downloading) w_nstate = S_LOAD;
            S_LOAD:  if (!downloading) w_nstate = S_DRAIN;
            S_DRAIN: if (!r_we && !r_skid_vld) begin
                w_nstate = S_HOLD;
                w_ncnt   = '0;
            end
            S_HOLD:  if (r_cnt == CW'(HOLD - 1)) w_nstate = S_RUN;
                     else w_ncnt = r_cnt + CW'(1);
            S_RUN:   if (downloading) w_nstate = S_LOAD;
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rst_game <= 1'b1;
        end else begin
            r_state    <= w_nstate;
            r_cnt      <= w_ncnt;
            r_rst_game <= (w_nstate != S_RUN);
        end
    end

    assign prog_we   = r_we;
    assign prog_ba   = r_out.ba;
    assign prog_addr = r_out.addr;
    assign prog_data = r_out.data;
    assign prog_mask = r_out.mask;
    assign prom_we   = r_prom_we;
    assign prom_addr = r_prom_addr;
    assign prom_data = r_prom_data;
    assign overrun   = r_ovr;
    assign oob       = r_oob;
    assign rst_game  = r_rst_game;

endmodule
